// File: rtl/gpu_ram_port_arbiter.sv
// gpu_ram_port_arbiter: 4-client round-robin byte port onto one 16-bit RAM port with tagged read return.
// Define GPU_ARB_RDATA_REG_EN to add an output register on rd_valid/rd_id/rd_data.
module gpu_ram_port_arbiter #(
    parameter int ADDR_SIZE   = 14,
    parameter int RAM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [3:0]  wr,
    input  logic [79:0] addr,
    input  logic [31:0] wdata,
    output logic [3:0]  ack,
    output logic        rd_valid,
    output logic [1:0]  rd_id,
    output logic [7:0]  rd_data,
    output logic        ram_wren,
    output logic [19:0] ram_addr,
    output logic [15:0] ram_data,
    output logic [1:0]  ram_byteena,
    input  logic [15:0] ram_q
);
    localparam logic [19:0] ADDR_MASK = 20'((64'd1 << ADDR_SIZE) - 64'd1);
    logic [1:0]  ptr, gid;
    logic        gnt;
    logic [3:0]  elig, tail;
    logic [19:0] a_sel;
    logic [3:0]  tag [RAM_LATENCY];
    // A client sees its ack one clock before its req drop reaches us, so ignore it for that clock.
    assign elig  = req & ~ack;
    assign a_sel = addr[20*gid +: 20];
    assign tail  = tag[RAM_LATENCY-1];
    always_comb begin
        gnt = 1'b0;
        gid = 2'd0;
        for (int i = 4; i >= 1; i--)
            if (elig[ptr + 2'(i)]) begin
                gnt = 1'b1;
                gid = ptr + 2'(i);
            end
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            ptr         <= 2'd3;
            ack         <= 4'd0;
            ram_wren    <= 1'b0;
            ram_byteena <= 2'b00;
            ram_addr    <= 20'd0;
            ram_data    <= 16'd0;
        end else begin
            ack         <= gnt ? 4'd1 << gid : 4'd0;
            ram_wren    <= gnt & wr[gid];
            ram_byteena <= gnt ? (a_sel[0] ? 2'b10 : 2'b01) : 2'b00;
            if (gnt) begin
                ptr      <= gid;
                ram_addr <= a_sel & ADDR_MASK;
                ram_data <= {2{wdata[8*gid +: 8]}};
            end
        end
    // Tag {valid, id, byte} follows the registered grant so the tail lines up with ram_q.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            for (int i = 0; i < RAM_LATENCY; i++)
                tag[i] <= 4'd0;
        end else begin
            tag[0] <= {(|ack) & ~ram_wren, ptr, ram_byteena[1]};
            for (int i = 1; i < RAM_LATENCY; i++)
                tag[i] <= tag[i-1];
        end
`ifdef GPU_ARB_RDATA_REG_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_id    <= 2'd0;
            rd_data  <= 8'd0;
        end else begin
            rd_valid <= tail[3];
            rd_id    <= tail[2:1];
            rd_data  <= tail[3] ? (tail[0] ? ram_q[15:8] : ram_q[7:0]) : 8'd0;
        end
`else
    always_comb begin
        rd_valid = tail[3];
        rd_id    = tail[2:1];
        rd_data  = tail[3] ? (tail[0] ? ram_q[15:8] : ram_q[7:0]) : 8'd0;
    end
`endif
endmodule

// File: tb/tb_gpu_ram_port_arbiter.sv
// tb_gpu_ram_port_arbiter: directed checks of grant order, RAM port fields and read return timing.
module tb_gpu_ram_port_arbiter;
`ifdef GPU_ARB_RDATA_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = 4'd0;
    logic [3:0]  wr = 4'd0;
    logic [79:0] addr = 80'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  ack;
    logic        rd_valid;
    logic [1:0]  rd_id;
    logic [7:0]  rd_data;
    logic        ram_wren;
    logic [19:0] ram_addr;
    logic [15:0] ram_data;
    logic [1:0]  ram_byteena;
    logic [15:0] ram_q = 16'h3C7E;
    int          vectors = 0;
    int          errors = 0;

    gpu_ram_port_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .ack(ack), .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
        .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_byteena(ram_byteena), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        req = 4'd0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ack"}, 32'(ack), 32'h0);
        check({tag, " rd_valid"}, 32'(rd_valid), 32'h0);
        check({tag, " rd_id"}, 32'(rd_id), 32'h0);
        check({tag, " rd_data"}, 32'(rd_data), 32'h0);
        check({tag, " ram_wren"}, 32'(ram_wren), 32'h0);
        check({tag, " ram_byteena"}, 32'(ram_byteena), 32'h0);
        check({tag, " ram_addr"}, 32'(ram_addr), 32'h0);
        check({tag, " ram_data"}, 32'(ram_data), 32'h0);
    endtask

    initial begin
        tick();
        check_all_zero("reset");
        reset_n = 1'b1;

        // client 2 write to 0x00011 with 0xA5: upper byte lane
        wr[2] = 1'b1;
        addr[40 +: 20] = 20'h00011;
        wdata[16 +: 8] = 8'hA5;
        req = 4'b0100;
        tick();
        check("wr ack", 32'(ack), 32'h4);
        check("wr wren", 32'(ram_wren), 32'h1);
        check("wr byteena", 32'(ram_byteena), 32'h2);
        check("wr data", 32'(ram_data), 32'hA5A5);
        check("wr addr", 32'(ram_addr), 32'h00011);
        req = 4'd0;
        tick();
        check("idle ack", 32'(ack), 32'h0);
        check("idle wren", 32'(ram_wren), 32'h0);
        check("idle byteena", 32'(ram_byteena), 32'h0);
        check("idle addr hold", 32'(ram_addr), 32'h00011);
        for (int t = 0; t < LAT + 1; t++) begin
            tick();
            check("wr no rd_valid", 32'(rd_valid), 32'h0);
        end

        // address bits above ADDR_SIZE are dropped; even address uses lower lane
        do_reset();
        wr = 4'd0;
        addr[60 +: 20] = 20'hFC002;
        wdata[24 +: 8] = 8'h5A;
        wr[3] = 1'b1;
        req = 4'b1000;
        tick();
        check("mask ack", 32'(ack), 32'h8);
        check("mask addr", 32'(ram_addr), 32'h00002);
        check("mask byteena", 32'(ram_byteena), 32'h1);
        check("mask data", 32'(ram_data), 32'h5A5A);
        req = 4'd0;
        wr = 4'd0;

        // all four requests held from reset: 0,1,2,3,0,1
        do_reset();
        req = 4'hF;
        for (int t = 0; t < 6; t++) begin
            tick();
            check("rr ack", 32'(ack), 32'(4'd1 << (t % 4)));
        end
        req = 4'd0;

        // client 1 reads, even then odd address
        for (int k = 0; k < 2; k++) begin
            do_reset();
            addr[20 +: 20] = (k == 0) ? 20'h00010 : 20'h00011;
            req = 4'b0010;
            tick();
            check("rd ack", 32'(ack), 32'h2);
            req = 4'd0;
            for (int t = 1; t < LAT; t++) begin
                tick();
                check("rd early", 32'(rd_valid), 32'h0);
            end
            tick();
            check("rd valid", 32'(rd_valid), 32'h1);
            check("rd id", 32'(rd_id), 32'h1);
            check("rd data", 32'(rd_data), (k == 0) ? 32'h7E : 32'h3C);
            tick();
            check("rd single", 32'(rd_valid), 32'h0);
        end

        // four back-to-back reads; client n at address n
        do_reset();
        for (int n = 0; n < 4; n++)
            addr[20*n +: 20] = 20'(n);
        req = 4'hF;
        for (int t = 1; t <= LAT + 5; t++) begin
            tick();
            check("b2b ack", 32'(ack), (t <= 4) ? 32'(4'd1 << (t - 1)) : 32'h0);
            req = req & ~((t <= 4) ? 4'(4'd1 << (t - 1)) : 4'd0);
            check("b2b rd_valid", 32'(rd_valid), (t > LAT && t <= LAT + 4) ? 32'h1 : 32'h0);
            if (t > LAT && t <= LAT + 4) begin
                check("b2b rd_id", 32'(rd_id), 32'(t - 1 - LAT));
                check("b2b rd_data", 32'(rd_data), ((t - 1 - LAT) % 2 == 1) ? 32'h3C : 32'h7E);
            end
        end

        // reset one clock after a read ack discards the in-flight tag
        do_reset();
        addr[0 +: 20] = 20'h00001;
        req = 4'b0001;
        tick();
        check("rst ack", 32'(ack), 32'h1);
        req = 4'd0;
        tick();
        reset_n = 1'b0;
        #1;
        check_all_zero("mid reset");
        tick();
        check_all_zero("held reset");
        reset_n = 1'b1;
        for (int t = 0; t < LAT + 2; t++) begin
            tick();
            check("post reset rd_valid", 32'(rd_valid), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
